m92_sound_latch: RTL and testbench

Bidirectional command/reply latch between the main V30 and the sound CPU. The main CPU's IO writes to port 0x00 feed a command path towards the sound CPU. The sound CPU's replies come back through a single reply register that the main CPU reads at IO port 0x08 (soundlatch2). The block drives a level interrupt to each side: to the sound CPU while commands are pending, and to the main CPU (via an m92_pic intp input) while a reply is unread.

---
 rtl/m92_sound_latch.sv | 177 +++++++++++++++++
 tb/tb_m92_sound_latch.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/m92_sound_latch.sv
// m92_sound_latch: command/reply latch between the main V30 and the sound CPU.
// The main CPU writes commands at IO 0x00 and reads replies at IO 0x08
// (soundlatch2). Each side receives a level interrupt while data waits for it.
// Build option: define M92_SNDLATCH_FIFO_EN to queue commands in a
// FIFO_DEPTH-entry FIFO. Without it, a single overwriting command register
// matches the original board.
module m92_sound_latch #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk_sys,
  input  logic       reset_n,
  input  logic       snd_reset_n,
  input  logic       main_cmd_wr,
  input  logic [7:0] main_din,
  input  logic       main_reply_rd,
  output logic [7:0] main_dout,
  output logic       main_irq,
  input  logic       snd_cmd_rd,
  output logic [7:0] snd_dout,
  input  logic       snd_reply_wr,
  input  logic [7:0] snd_din,
  output logic       snd_irq,
  output logic [4:0] cmd_count,
  output logic       cmd_overflow
);

  localparam int DATA_W = 8;
  localparam logic [DATA_W-1:0] EMPTY_BYTE = 8'hFF;

  if (FIFO_DEPTH < 2 || FIFO_DEPTH > 16 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("m92_sound_latch: FIFO_DEPTH must be a power of two in 2..16");
  end

  // Registered copies of the strobes; an action fires only on the first high cycle.
  logic cmd_wr_p0;
  logic cmd_rd_p0;
  logic reply_wr_p0;
  logic reply_rd_p0;

  // Strobe history keeps updating while the sound CPU is held in reset, so a
  // strobe still high at release is not seen as a new edge.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      cmd_wr_p0   <= 1'b0;
      cmd_rd_p0   <= 1'b0;
      reply_wr_p0 <= 1'b0;
      reply_rd_p0 <= 1'b0;
    end else begin
      cmd_wr_p0   <= main_cmd_wr;
      cmd_rd_p0   <= snd_cmd_rd;
      reply_wr_p0 <= snd_reply_wr;
      reply_rd_p0 <= main_reply_rd;
    end
  end

  logic cmd_wr_edge;
  logic cmd_rd_edge;
  logic reply_wr_edge;
  logic reply_rd_edge;

  assign cmd_wr_edge   = main_cmd_wr   & ~cmd_wr_p0   & snd_reset_n;
  assign cmd_rd_edge   = snd_cmd_rd    & ~cmd_rd_p0   & snd_reset_n;
  assign reply_wr_edge = snd_reply_wr  & ~reply_wr_p0 & snd_reset_n;
  assign reply_rd_edge = main_reply_rd & ~reply_rd_p0 & snd_reset_n;

  // ---------------------------------------------------------------------------
  // Reply path: sound CPU -> main CPU
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] reply_data;
  logic              reply_pend;

  // A new reply takes priority over a simultaneous read, so the main CPU never
  // loses a reply it has not yet seen.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      reply_data <= EMPTY_BYTE;
      reply_pend <= 1'b0;
    end else if (reply_wr_edge) begin
      reply_data <= snd_din;
      reply_pend <= 1'b1;
    end else if (!snd_reset_n || reply_rd_edge) begin
      reply_pend <= 1'b0;
    end
  end

  assign main_dout = reply_data;
  assign main_irq  = reply_pend;

  // ---------------------------------------------------------------------------
  // Command path: main CPU -> sound CPU
  // ---------------------------------------------------------------------------
`ifdef M92_SNDLATCH_FIFO_EN
  localparam int          PTR_W   = $clog2(FIFO_DEPTH);
  localparam logic [4:0]  DEPTH_C = 5'(FIFO_DEPTH);

  logic [DATA_W-1:0] cmd_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [4:0]        count;
  logic              overflow;
  logic              is_empty;
  logic              is_full;
  logic              do_pop;
  logic              do_push;

  // A pop on a full FIFO frees the slot the simultaneous write needs.
  always_comb begin
    is_empty = (count == 5'd0);
    is_full  = (count == DEPTH_C);
    do_pop   = cmd_rd_edge & ~is_empty;
    do_push  = cmd_wr_edge & (~is_full | do_pop);
  end

  // Pointer, occupancy and overflow bookkeeping; pointers wrap naturally at
  // the power-of-two depth.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= 5'd0;
      overflow <= 1'b0;
    end else if (!snd_reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= 5'd0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + 5'(do_push) - 5'(do_pop);
      if (cmd_wr_edge && is_full && !do_pop) overflow <= 1'b1;
    end
  end

  // Command storage carries no reset; stale bytes are hidden by the count.
  always_ff @(posedge clk_sys) begin
    if (do_push) cmd_mem[wr_ptr] <= main_din;
  end

  assign snd_dout     = is_empty ? EMPTY_BYTE : cmd_mem[rd_ptr];
  assign snd_irq      = ~is_empty;
  assign cmd_count    = count;
  assign cmd_overflow = overflow;
`else
  logic [DATA_W-1:0] cmd_data;
  logic              cmd_pend;
  logic              overflow;

  // Single latch: a write always wins, and writing over an unread command
  // flags the loss.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      cmd_pend <= 1'b0;
      overflow <= 1'b0;
    end else if (!snd_reset_n) begin
      cmd_pend <= 1'b0;
      overflow <= 1'b0;
    end else if (cmd_wr_edge) begin
      cmd_pend <= 1'b1;
      if (cmd_pend) overflow <= 1'b1;
    end else if (cmd_rd_edge) begin
      cmd_pend <= 1'b0;
    end
  end

  // Command byte storage; only meaningful while cmd_pend is set.
  always_ff @(posedge clk_sys) begin
    if (cmd_wr_edge) cmd_data <= main_din;
  end

  assign snd_dout     = cmd_pend ? cmd_data : EMPTY_BYTE;
  assign snd_irq      = cmd_pend;
  assign cmd_count    = {4'b0000, cmd_pend};
  assign cmd_overflow = overflow;
`endif

endmodule

// File: tb/tb_m92_sound_latch.sv
// Self-checking bench for m92_sound_latch. A queue-based model follows the
// latch rules cycle by cycle; directed literal checks pin the model.
// Works for both builds (M92_SNDLATCH_FIFO_EN defined or not).
module tb_m92_sound_latch;

  localparam int DEPTH = 4;

  logic       clk_sys = 1'b0;
  logic       reset_n;
  logic       snd_reset_n;
  logic       main_cmd_wr;
  logic [7:0] main_din;
  logic       main_reply_rd;
  logic [7:0] main_dout;
  logic       main_irq;
  logic       snd_cmd_rd;
  logic [7:0] snd_dout;
  logic       snd_reply_wr;
  logic [7:0] snd_din;
  logic       snd_irq;
  logic [4:0] cmd_count;
  logic       cmd_overflow;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  m92_sound_latch #(.FIFO_DEPTH(DEPTH)) dut (
    .clk_sys      (clk_sys),
    .reset_n      (reset_n),
    .snd_reset_n  (snd_reset_n),
    .main_cmd_wr  (main_cmd_wr),
    .main_din     (main_din),
    .main_reply_rd(main_reply_rd),
    .main_dout    (main_dout),
    .main_irq     (main_irq),
    .snd_cmd_rd   (snd_cmd_rd),
    .snd_dout     (snd_dout),
    .snd_reply_wr (snd_reply_wr),
    .snd_din      (snd_din),
    .snd_irq      (snd_irq),
    .cmd_count    (cmd_count),
    .cmd_overflow (cmd_overflow)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0] m_q[$];
  bit         m_ovf;
  logic [7:0] m_rep;
  bit         m_rep_pend;
  bit         pw, pr, prw, prr;

  initial begin
    m_rep = 8'hFF;
    forever begin
      @(posedge clk_sys);
      if (!reset_n) begin
        m_q.delete();
        m_ovf = 0; m_rep = 8'hFF; m_rep_pend = 0;
        pw = 0; pr = 0; prw = 0; prr = 0;
      end else begin
        bit we, re, rwe, rre;
        we  = main_cmd_wr   && !pw  && snd_reset_n;
        re  = snd_cmd_rd    && !pr  && snd_reset_n;
        rwe = snd_reply_wr  && !prw && snd_reset_n;
        rre = main_reply_rd && !prr && snd_reset_n;
        if (!snd_reset_n) begin
          m_q.delete();
          m_ovf = 0;
          m_rep_pend = 0;
        end else begin
`ifdef M92_SNDLATCH_FIFO_EN
          if (re && m_q.size() > 0) void'(m_q.pop_front());
          if (we) begin
            if (m_q.size() < DEPTH) m_q.push_back(main_din);
            else m_ovf = 1;
          end
`else
          if (we) begin
            if (m_q.size() > 0) m_ovf = 1;
            m_q.delete();
            m_q.push_back(main_din);
          end else if (re) begin
            m_q.delete();
          end
`endif
          if (rwe) begin
            m_rep = snd_din;
            m_rep_pend = 1;
          end else if (rre) begin
            m_rep_pend = 0;
          end
        end
        pw = main_cmd_wr; pr = snd_cmd_rd; prw = snd_reply_wr; prr = main_reply_rd;
      end
    end
  end

  // Compare every output against the model on each falling edge.
  initial begin
    forever begin
      @(negedge clk_sys);
      if (cmp_en) begin
        if (!reset_n) begin
          check("cmp_rst_snd_dout", snd_dout, 8'hFF);
          check("cmp_rst_main_dout", main_dout, 8'hFF);
          check("cmp_rst_count", cmd_count, 0);
        end else begin
          check("cmp_snd_dout", snd_dout, (m_q.size() > 0) ? m_q[0] : 8'hFF);
          check("cmp_snd_irq", snd_irq, (m_q.size() != 0) ? 1 : 0);
          check("cmp_cmd_count", cmd_count, m_q.size());
          check("cmp_overflow", cmd_overflow, m_ovf);
          check("cmp_main_dout", main_dout, m_rep);
          check("cmp_main_irq", main_irq, m_rep_pend);
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic cmd_write(input logic [7:0] b);
    main_din = b; main_cmd_wr = 1; tick();
    main_cmd_wr = 0; tick();
  endtask

  task automatic cmd_read();
    snd_cmd_rd = 1; tick();
    snd_cmd_rd = 0; tick();
  endtask

  task automatic reply_write(input logic [7:0] b);
    snd_din = b; snd_reply_wr = 1; tick();
    snd_reply_wr = 0; tick();
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    reset_n = 0; snd_reset_n = 1;
    main_cmd_wr = 0; main_din = 8'h00; main_reply_rd = 0;
    snd_cmd_rd = 0; snd_reply_wr = 0; snd_din = 8'h00;
    tick(); tick();
    cmp_en = 1;
    reset_n = 1;
    tick(); tick();

    check("rst_snd_dout", snd_dout, 8'hFF);
    check("rst_main_dout", main_dout, 8'hFF);
    check("rst_main_irq", main_irq, 0);
    check("rst_snd_irq", snd_irq, 0);
    check("rst_count", cmd_count, 0);
    check("rst_overflow", cmd_overflow, 0);

    // Write latency: visible one cycle after the edge.
    main_din = 8'h11; main_cmd_wr = 1; tick();
    check("wr_lat_irq", snd_irq, 1);
    check("wr_lat_dout", snd_dout, 8'h11);
    main_cmd_wr = 0; tick();

`ifdef M92_SNDLATCH_FIFO_EN
    cmd_write(8'h22); cmd_write(8'h33);
    check("fifo3_count", cmd_count, 3);
    check("fifo3_irq", snd_irq, 1);
    check("fifo3_head", snd_dout, 8'h11);
    cmd_read(); check("fifo_pop1", snd_dout, 8'h22);
    cmd_read(); check("fifo_pop2", snd_dout, 8'h33);
    cmd_read(); check("fifo_pop3", snd_dout, 8'hFF);
    check("fifo_empty_irq", snd_irq, 0);

    for (int i = 0; i < 5; i++) cmd_write(8'hA0 + 8'(i));
    check("fifo_full_count", cmd_count, 4);
    check("fifo_full_ovf", cmd_overflow, 1);
    for (int i = 0; i < 4; i++) begin
      check("fifo_drain", snd_dout, 8'hA0 + i);
      cmd_read();
    end
    check("fifo_drained", cmd_count, 0);

    // Simultaneous write and read on empty: write stored, read ignored.
    main_din = 8'h44; main_cmd_wr = 1; snd_cmd_rd = 1; tick();
    main_cmd_wr = 0; snd_cmd_rd = 0; tick();
    check("fifo_both_empty", cmd_count, 1);
    check("fifo_both_empty_dout", snd_dout, 8'h44);
    cmd_write(8'h45); cmd_write(8'h46); cmd_write(8'h47);
    // Full: pop and push together, no new overflow beyond the sticky one.
    main_din = 8'h48; main_cmd_wr = 1; snd_cmd_rd = 1; tick();
    main_cmd_wr = 0; snd_cmd_rd = 0; tick();
    check("fifo_both_full_count", cmd_count, 4);
    check("fifo_both_full_head", snd_dout, 8'h45);
    for (int i = 0; i < 4; i++) cmd_read();
`else
    check("sr_first", snd_dout, 8'h11);
    cmd_read();
    check("sr_read_clear", snd_irq, 0);
    cmd_write(8'h05); cmd_write(8'h06);
    check("sr_overwrite", snd_dout, 8'h06);
    check("sr_overflow", cmd_overflow, 1);
    check("sr_count", cmd_count, 1);
    main_din = 8'h07; main_cmd_wr = 1; snd_cmd_rd = 1; tick();
    main_cmd_wr = 0; snd_cmd_rd = 0; tick();
    check("sr_both_pend", snd_irq, 1);
    check("sr_both_dout", snd_dout, 8'h07);
    cmd_read();
    check("sr_final_empty", cmd_count, 0);
`endif

    // Reply path.
    snd_din = 8'h7E; snd_reply_wr = 1; tick();
    check("rep_irq", main_irq, 1);
    check("rep_dout", main_dout, 8'h7E);
    snd_reply_wr = 0; tick();
    main_reply_rd = 1; tick();
    check("rep_rd_clear", main_irq, 0);
    tick(); tick();
    main_reply_rd = 0; tick();
    check("rep_held_once", main_irq, 0);
    reply_write(8'h5A);
    check("rep_reassert", main_irq, 1);
    check("rep_new_data", main_dout, 8'h5A);
    // Simultaneous reply write and read: write wins.
    snd_din = 8'h3C; snd_reply_wr = 1; main_reply_rd = 1; tick();
    snd_reply_wr = 0; main_reply_rd = 0; tick();
    check("rep_both_pend", main_irq, 1);
    check("rep_both_data", main_dout, 8'h3C);

    // Sound CPU reset with commands queued and a reply pending.
    cmd_write(8'hC1); cmd_write(8'hC2);
`ifdef M92_SNDLATCH_FIFO_EN
    check("srst_pre_count", cmd_count, 2);
`else
    check("srst_pre_count", cmd_count, 1);
`endif
    snd_reset_n = 0; main_din = 8'h99; main_cmd_wr = 1; tick(); tick();
    check("srst_count", cmd_count, 0);
    check("srst_snd_irq", snd_irq, 0);
    check("srst_main_irq", main_irq, 0);
    check("srst_ovf", cmd_overflow, 0);
    snd_reset_n = 1; tick(); tick();
    check("srst_held_wr", cmd_count, 0);
    main_cmd_wr = 0; tick();
    check("srst_after", snd_dout, 8'hFF);

    // Mixed directed strobe patterns, checked by the model every cycle.
    for (int i = 0; i < 48; i++) begin
      main_din     = 8'(i * 37 + 5);
      snd_din      = 8'(i * 11 + 3);
      main_cmd_wr  = (i % 3) != 2;
      snd_cmd_rd   = (i % 5) == 1 || (i % 7) == 3;
      snd_reply_wr = (i % 4) == 0;
      main_reply_rd = (i % 6) >= 3;
      snd_reset_n  = (i != 30);
      tick();
    end
    main_cmd_wr = 0; snd_cmd_rd = 0; snd_reply_wr = 0; main_reply_rd = 0;
    snd_reset_n = 1;
    tick();

    // Asynchronous reset mid-operation clears everything immediately.
    cmd_write(8'hE1); reply_write(8'hE2);
    check("arst_pre_irq", snd_irq, 1);
    reset_n = 0; #2;
    check("arst_snd_dout", snd_dout, 8'hFF);
    check("arst_snd_irq", snd_irq, 0);
    check("arst_main_irq", main_irq, 0);
    check("arst_main_dout", main_dout, 8'hFF);
    check("arst_count", cmd_count, 0);
    tick();
    reset_n = 1; tick(); tick();
    check("arst_after", cmd_count, 0);

    cmp_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
